// File: rtl/serial_frame_rx.sv
// Serial command-frame receiver: deserialises type/data/parity words
// and presents N args plus a command as one frame on valid/ready.
module serial_frame_rx #(
   parameter  int DATA_W   = 8,
   parameter  int MAX_ARGS = 9,
   parameter  int MIN_ARGS = 2,
   localparam int NARGS_W  = $clog2(MAX_ARGS + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       din,
   input  logic                       enable_n,
   output logic                       frm_valid,
   input  logic                       frm_ready,
   output logic [DATA_W-1:0]          frm_cmd,
   output logic [MAX_ARGS*DATA_W-1:0] frm_args,
   output logic [NARGS_W-1:0]         frm_nargs,
   output logic [3:0]                 frm_status,
   output logic                       busy
);

   localparam int WORD_W = DATA_W + 2;
   localparam int CNT_W  = $clog2(WORD_W);

   typedef enum logic [1:0] {IDLE, RECV, HOLD, SKIP} state_t;

   state_t              state;
   logic [WORD_W-2:0]   sr;
   logic [CNT_W-1:0]    cnt;
   logic                par_err;
   logic                ovf;
   logic                drop_pend;

   logic [WORD_W-1:0]   word;
   logic                word_done;
   logic                word_bad;
   logic                full;
   logic                cnt_err;

   // word is only meaningful on the cycle its final (parity) bit arrives
   assign word      = {sr, din};
   assign word_done = (cnt == CNT_W'(WORD_W - 1));
   assign word_bad  = ^word;
   assign full      = (frm_nargs == NARGS_W'(MAX_ARGS));
   assign cnt_err   = ovf | (frm_nargs < NARGS_W'(MIN_ARGS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sr         <= '0;
         cnt        <= '0;
         par_err    <= 1'b0;
         ovf        <= 1'b0;
         drop_pend  <= 1'b0;
         frm_valid  <= 1'b0;
         busy       <= 1'b0;
         frm_cmd    <= '0;
         frm_args   <= '0;
         frm_nargs  <= '0;
         frm_status <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!enable_n) begin
                  sr    <= (WORD_W-1)'(din);
                  cnt   <= CNT_W'(1);
                  state <= RECV;
               end
            end
            RECV: begin
               if (enable_n) begin
                  state      <= HOLD;
                  frm_valid  <= 1'b1;
                  busy       <= 1'b1;
                  frm_cmd    <= '0;
                  frm_status <= {drop_pend, 1'b1, cnt_err, par_err};
                  drop_pend  <= 1'b0;
                  cnt        <= '0;
               end else if (!word_done) begin
                  sr  <= word[WORD_W-2:0];
                  cnt <= cnt + 1'b1;
               end else begin
                  sr  <= word[WORD_W-2:0];
                  cnt <= '0;
                  if (word[WORD_W-1]) begin
                     state      <= HOLD;
                     frm_valid  <= 1'b1;
                     busy       <= 1'b1;
                     frm_cmd    <= word[WORD_W-2:1];
                     frm_status <= {drop_pend, 1'b0, cnt_err,
                                    par_err | word_bad};
                     drop_pend  <= 1'b0;
                  end else begin
                     par_err <= par_err | word_bad;
                     if (!full) begin
                        frm_args[int'(frm_nargs)*DATA_W +: DATA_W]
                           <= word[WORD_W-2:1];
                        frm_nargs <= frm_nargs + 1'b1;
                     end else begin
                        ovf <= 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               // input seen while a frame is held is lost; flag it on the next frame
               if (!enable_n) drop_pend <= 1'b1;
               if (frm_ready) begin
                  frm_valid  <= 1'b0;
                  busy       <= 1'b0;
                  frm_cmd    <= '0;
                  frm_args   <= '0;
                  frm_nargs  <= '0;
                  frm_status <= '0;
                  par_err    <= 1'b0;
                  ovf        <= 1'b0;
                  state      <= enable_n ? IDLE : SKIP;
               end
            end
            SKIP: begin
               if (enable_n) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
